control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
- Hardwired Moore control unit directly upstream of the DataPath.
- Generates the per-T-state register in/out strobes, memory read request and ALU select that the DataPath consumes; these replace hand-driven bench signals.
- Covers instruction fetch plus execute of register-register ALU ops, ldi, nop and halt, with one memory wait handshake.

Parameters:
- OP_WIDTH, 5, opcode field width (IR[31:27])
- ALUSEL_WIDTH, 4, width of ALU operation select

Ports:
- clock  in  1  system clock, rising edge
- clear  in  1  synchronous active-high reset
- start  in  1  leave IDLE/HALTED and begin fetch
- stop  in  1  request halt at next instruction boundary
- opcode  in  OP_WIDTH  IR[31:27] from DataPath; stable T3..T5
- mem_ready  in  1  memory read data valid on Mdatain
- PCout, PCin, IncPC, MARin  out  1 each  PC/MAR strobes
- Read, MDRin, MDRout, IRin  out  1 each  memory/IR strobes
- Yin, Zin, Zlowout  out  1 each  ALU operand/result strobes
- Gra, Grb, Grc, Rin, Rout, BAout, Cout  out  1 each  register-select and immediate strobes
- alu_sel  out  ALUSEL_WIDTH  ALU operation; ALU_NOP when unused
- run  out  1  high in T0..T5, low in IDLE/HALTED
- illegal_op  out  1  one-cycle pulse in T3 for an unsupported opcode

Behaviour:
- States: IDLE, T0, T1, T2, T3, T4, T5, HALTED. State is registered; all outputs decode from state and opcode only (Moore).
- Reset: clear=1 at a rising edge puts the FSM in IDLE from any state, including mid-T1 wait.
  - In IDLE every strobe, run and illegal_op are 0 and alu_sel = ALU_NOP.
  - clear dominates start, stop and mem_ready.
- IDLE/HALTED -> T0 when start=1. Otherwise the FSM holds.
- T0: PCout, MARin, IncPC, Zin. Always -> T1.
- T1: Zlowout, PCin, Read, MDRin.
  - Holds in T1 while mem_ready=0, with strobes held asserted.
  - -> T2 on the edge where mem_ready=1.
  - PCin is asserted every T1 cycle; rewriting the same PC value is harmless.
- T2: MDRout, IRin. -> T3.
- T3, by opcode:
  - add 00011, sub 00100, and 00101, or 00110: Grb, Rout, Yin. -> T4.
  - ldi 00001: Grb, BAout, Yin. -> T4.
  - nop 11010: no strobes. -> T0, or -> HALTED if the stop latch is set.
  - halt 11011: no strobes. -> HALTED.
  - Any other opcode: illegal_op=1, then treated as nop.
- T4:
  - ALU ops: Grc, Rout, Zin, alu_sel = ALU_ADD / ALU_SUB / ALU_AND / ALU_OR.
  - ldi: Cout, Zin, alu_sel = ALU_ADD.
  - -> T5.
- T5: Zlowout, Gra, Rin. -> T0, or -> HALTED if the stop latch is set.
- Stop latch:
  - Set when stop=1 in any running state.
  - Cleared on entry to HALTED and by clear.
  - Stop never aborts an instruction mid-way.
- Latency: ALU/ldi instruction = 6 cycles + (mem_ready wait cycles). nop = 4 cycles + wait.
- start while running is ignored. start and stop together in HALTED: start wins, and stop is latched.

Optional Feature:
- SINGLE_STEP_EN defined:
  - Adds input step (1 bit).
  - Every state transition out of T0..T5 additionally requires step=1 that cycle; strobes are held while waiting. The T1 advance needs mem_ready=1 and step=1 in the same cycle.
- Undefined: the step port is absent and transitions occur as above.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - state enum
  - opcode constants (OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOP, OP_HALT)
  - alu_sel constants (ALU_NOP, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR)
- One natural sub-module, ctrl_decode: combinational state+opcode -> strobe vector, kept separate from the next-state register.

Test Plan:
- clear=1 two cycles with start=1 -> stays IDLE, all outputs 0, run=0; release clear, start=1 -> T0 next cycle with PCout=MARin=IncPC=Zin=1.
- opcode=00011, mem_ready=1 in first T1 cycle -> T0..T5 in 6 cycles; T4 alu_sel=ALU_ADD with Grc, Rout, Zin; T5 Gra, Rin, Zlowout; then T0.
- mem_ready held 0 for 3 cycles in T1 -> Read/MDRin held 4 cycles; T2 IRin one cycle after mem_ready=1.
- opcode=00001 (ldi) -> T3 BAout, Yin, Grb; T4 Cout, alu_sel=ALU_ADD.
- opcode=11011 -> HALTED after T3, run=0; start=1 -> T0. opcode=11111 -> illegal_op pulses once in T3, then T0.
- stop=1 during T1 of opcode=00100 -> instruction completes (T4 alu_sel=ALU_SUB), then HALTED; clear asserted mid-T4 -> IDLE next edge.

Source files
------------

// File: rtl/control_sequencer_pkg.sv
// Shared types and encodings for the hardwired control sequencer.
package cpu_ctrl_pkg;

    localparam int CTRL_OP_W  = 5;
    localparam int CTRL_ALU_W = 4;

    typedef enum logic [2:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_HALTED
    } state_t;

    localparam logic [CTRL_OP_W-1:0] OP_LDI  = 5'b00001;
    localparam logic [CTRL_OP_W-1:0] OP_ADD  = 5'b00011;
    localparam logic [CTRL_OP_W-1:0] OP_SUB  = 5'b00100;
    localparam logic [CTRL_OP_W-1:0] OP_AND  = 5'b00101;
    localparam logic [CTRL_OP_W-1:0] OP_OR   = 5'b00110;
    localparam logic [CTRL_OP_W-1:0] OP_NOP  = 5'b11010;
    localparam logic [CTRL_OP_W-1:0] OP_HALT = 5'b11011;

    localparam logic [CTRL_ALU_W-1:0] ALU_NOP = 4'd0;
    localparam logic [CTRL_ALU_W-1:0] ALU_ADD = 4'd1;
    localparam logic [CTRL_ALU_W-1:0] ALU_SUB = 4'd2;
    localparam logic [CTRL_ALU_W-1:0] ALU_AND = 4'd3;
    localparam logic [CTRL_ALU_W-1:0] ALU_OR  = 4'd4;

    typedef struct packed {
        logic pcout, pcin, incpc, marin;
        logic read, mdrin, mdrout, irin;
        logic yin, zin, zlowout;
        logic gra, grb, grc, rin, rout, baout, cout;
        logic [CTRL_ALU_W-1:0] alu_sel;
        logic run;
        logic illegal_op;
    } strobe_t;

    function automatic logic is_alu_op(input logic [CTRL_OP_W-1:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
    endfunction

endpackage

// File: rtl/control_sequencer_decode.sv
// Moore output decode: state + opcode -> DataPath strobe vector.
module ctrl_decode
    import cpu_ctrl_pkg::*;
(
    input  state_t               state,
    input  logic [CTRL_OP_W-1:0] opcode,
    output strobe_t              strb
);

    always_comb begin
        strb         = '0;
        strb.alu_sel = ALU_NOP;
        strb.run     = (state != S_IDLE) && (state != S_HALTED);
        case (state)
            S_T0: begin
                strb.pcout = 1'b1; strb.marin = 1'b1;
                strb.incpc = 1'b1; strb.zin   = 1'b1;
            end
            S_T1: begin
                strb.zlowout = 1'b1; strb.pcin  = 1'b1;
                strb.read    = 1'b1; strb.mdrin = 1'b1;
            end
            S_T2: begin
                strb.mdrout = 1'b1; strb.irin = 1'b1;
            end
            S_T3: begin
                if (is_alu_op(opcode)) begin
                    strb.grb = 1'b1; strb.rout = 1'b1; strb.yin = 1'b1;
                end else if (opcode == OP_LDI) begin
                    strb.grb = 1'b1; strb.baout = 1'b1; strb.yin = 1'b1;
                end else if (opcode != OP_NOP && opcode != OP_HALT) begin
                    strb.illegal_op = 1'b1;
                end
            end
            S_T4: begin
                strb.zin = 1'b1;
                if (opcode == OP_LDI) begin
                    strb.cout    = 1'b1;
                    strb.alu_sel = ALU_ADD;
                end else begin
                    strb.grc  = 1'b1;
                    strb.rout = 1'b1;
                    case (opcode)
                        OP_ADD:  strb.alu_sel = ALU_ADD;
                        OP_SUB:  strb.alu_sel = ALU_SUB;
                        OP_AND:  strb.alu_sel = ALU_AND;
                        OP_OR:   strb.alu_sel = ALU_OR;
                        default: strb.alu_sel = ALU_NOP;
                    endcase
                end
            end
            S_T5: begin
                strb.zlowout = 1'b1; strb.gra = 1'b1; strb.rin = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Moore control sequencer: fetch + reg/reg ALU, ldi, nop, halt.
// Optional SINGLE_STEP_EN adds a step input gating every running-state advance.
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int OP_WIDTH     = 5,
    parameter int ALUSEL_WIDTH = 4
) (
    input  logic                    clock,
    input  logic                    clear,
    input  logic                    start,
    input  logic                    stop,
`ifdef SINGLE_STEP_EN
    input  logic                    step,
`endif
    input  logic [OP_WIDTH-1:0]     opcode,
    input  logic                    mem_ready,
    output logic                    PCout, PCin, IncPC, MARin,
    output logic                    Read, MDRin, MDRout, IRin,
    output logic                    Yin, Zin, Zlowout,
    output logic                    Gra, Grb, Grc, Rin, Rout, BAout, Cout,
    output logic [ALUSEL_WIDTH-1:0] alu_sel,
    output logic                    run,
    output logic                    illegal_op
);

    state_t  state, state_nx;
    logic    stop_lat;
    logic    adv;
    strobe_t strb;

`ifdef SINGLE_STEP_EN
    assign adv = step;
`else
    assign adv = 1'b1;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_HALTED: if (start) state_nx = S_T0;
            S_T0: if (adv) state_nx = S_T1;
            S_T1: if (adv && mem_ready) state_nx = S_T2;
            S_T2: if (adv) state_nx = S_T3;
            S_T3: if (adv) begin
                if (is_alu_op(opcode) || opcode == OP_LDI) state_nx = S_T4;
                else if (opcode == OP_HALT)                state_nx = S_HALTED;
                else                                       state_nx = stop_lat ? S_HALTED : S_T0;
            end
            S_T4: if (adv) state_nx = S_T5;
            S_T5: if (adv) state_nx = stop_lat ? S_HALTED : S_T0;
            default: state_nx = S_IDLE;
        endcase
    end

    // Entering HALTED consumes the latch; start+stop in HALTED re-arms it.
    always_ff @(posedge clock) begin
        if (clear) begin
            state    <= S_IDLE;
            stop_lat <= 1'b0;
        end else begin
            state <= state_nx;
            if (state_nx == S_HALTED && state != S_HALTED)
                stop_lat <= 1'b0;
            else if (stop && (strb.run || start))
                stop_lat <= 1'b1;
        end
    end

    ctrl_decode u_decode (
        .state  (state),
        .opcode (opcode),
        .strb   (strb)
    );

    assign PCout      = strb.pcout;
    assign PCin       = strb.pcin;
    assign IncPC      = strb.incpc;
    assign MARin      = strb.marin;
    assign Read       = strb.read;
    assign MDRin      = strb.mdrin;
    assign MDRout     = strb.mdrout;
    assign IRin       = strb.irin;
    assign Yin        = strb.yin;
    assign Zin        = strb.zin;
    assign Zlowout    = strb.zlowout;
    assign Gra        = strb.gra;
    assign Grb        = strb.grb;
    assign Grc        = strb.grc;
    assign Rin        = strb.rin;
    assign Rout       = strb.rout;
    assign BAout      = strb.baout;
    assign Cout       = strb.cout;
    assign alu_sel    = strb.alu_sel;
    assign run        = strb.run;
    assign illegal_op = strb.illegal_op;

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized scoreboard bench for control_sequencer against a per-instruction cycle model.
module tb_control_sequencer;
    import cpu_ctrl_pkg::*;

    logic clock = 1'b0;
    logic clear, start, stop, mem_ready;
    logic [4:0] opcode;
    logic PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin;
    logic Yin, Zin, Zlowout, Gra, Grb, Grc, Rin, Rout, BAout, Cout;
    logic [3:0] alu_sel;
    logic run, illegal_op;
`ifdef SINGLE_STEP_EN
    logic step = 1'b1;
`endif

    always #5 clock = ~clock;

    control_sequencer dut (
        .clock(clock), .clear(clear), .start(start), .stop(stop),
`ifdef SINGLE_STEP_EN
        .step(step),
`endif
        .opcode(opcode), .mem_ready(mem_ready),
        .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin),
        .Read(Read), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin),
        .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
        .BAout(BAout), .Cout(Cout),
        .alu_sel(alu_sel), .run(run), .illegal_op(illegal_op)
    );

    // Observed vector: 18 strobes, alu_sel[5:2], run[1], illegal_op[0].
    wire [23:0] act = {PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin,
                       Yin, Zin, Zlowout, Gra, Grb, Grc, Rin, Rout, BAout, Cout,
                       alu_sel, run, illegal_op};

    function automatic logic [23:0] b(input int n);
        return 24'd1 << n;
    endfunction

    function automatic logic [23:0] sel(input logic [3:0] s);
        return {18'd0, s, 2'd0};
    endfunction

    function automatic bit is_alu(input logic [4:0] op);
        return op == 5'b00011 || op == 5'b00100 || op == 5'b00101 || op == 5'b00110;
    endfunction

    function automatic bit is_legal(input logic [4:0] op);
        return is_alu(op) || op == 5'b00001 || op == 5'b11010 || op == 5'b11011;
    endfunction

    // Expected outputs for phase ph (0..5 = T0..T5, 6 = idle/halted).
    function automatic logic [23:0] model(input int ph, input logic [4:0] op);
        logic [23:0] e;
        e = 24'd0;
        case (ph)
            0: e = b(23) | b(20) | b(21) | b(14);
            1: e = b(13) | b(22) | b(19) | b(18);
            2: e = b(17) | b(16);
            3: if (is_alu(op) || op == 5'b00001)
                   e = b(11) | b(15) | ((op == 5'b00001) ? b(7) : b(8));
               else if (op != 5'b11010 && op != 5'b11011)
                   e = b(0);
            4: if (op == 5'b00001) e = b(6) | b(14) | sel(ALU_ADD);
               else e = b(10) | b(8) | b(14) |
                        sel(op == 5'b00011 ? ALU_ADD : op == 5'b00100 ? ALU_SUB :
                            op == 5'b00101 ? ALU_AND : ALU_OR);
            5: e = b(13) | b(12) | b(9);
            default: e = 24'd0;
        endcase
        if (ph < 6) e = e | b(1);
        return e;
    endfunction

    logic [23:0] exp_q[$];
    string       tag_q[$];
    int checks = 0, errors = 0, cyc = 0;
    bit pending = 0;

    always @(negedge clock) begin
        cyc++;
        if (exp_q.size() > 0) begin
            logic [23:0] e;
            string t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL %s cyc=%0d got=%h want=%h", t, cyc, act, e);
            end
        end
    end

    task automatic tick(input logic [23:0] e, input string t, input logic mr,
                        input logic st, input logic sp, input logic clr);
        mem_ready = mr; start = st; stop = sp; clear = clr;
        exp_q.push_back(e);
        tag_q.push_back(t);
        @(posedge clock); #1;
    endtask

    // Run one instruction starting in T0; stopc/clrc select the cycle index that asserts stop/clear.
    task automatic do_instr(input logic [4:0] op, input int w, input int stopc,
                            input int clrc, output bit halted);
        int seq[$];
        int last_t1;
        bit go_halt;
        string t;
        seq.push_back(0);
        for (int k = 0; k <= w; k++) seq.push_back(1);
        last_t1 = seq.size() - 1;
        seq.push_back(2);
        seq.push_back(3);
        if (is_alu(op) || op == 5'b00001) begin
            seq.push_back(4);
            seq.push_back(5);
        end
        opcode = op;
        halted = 0;
        for (int i = 0; i < seq.size(); i++) begin
            logic mr, sp, clr;
            mr  = (seq[i] == 1) ? (i == last_t1) : 1'($urandom);
            sp  = (i == stopc);
            clr = (i == clrc);
            t = $sformatf("op%b_T%0d", op, seq[i]);
            tick(model(seq[i], op), t, mr, 1'($urandom), sp, clr);
            if (clr) begin
                pending = 0;
                halted  = 1;
                return;
            end
            if (i == seq.size() - 1) begin
                go_halt = (op == 5'b11011) || pending;
                if (go_halt) pending = 0;
                else pending = pending | sp;
                halted = go_halt;
            end else begin
                pending = pending | sp;
            end
        end
    endtask

    // From IDLE/HALTED: a few parked cycles, then start (optionally with stop).
    task automatic resume(input int park, input logic sp);
        for (int k = 0; k < park; k++)
            tick(model(6, 5'b0), "parked", 1'($urandom), 1'b0, 1'b0, 1'b0);
        tick(model(6, 5'b0), "start_cycle", 1'($urandom), 1'b1, sp, 1'b0);
        if (sp) pending = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        bit h;
        logic [4:0] op;
        clear = 1; start = 1; stop = 0; mem_ready = 0; opcode = 5'b0;
        @(posedge clock); #1;
        tick(model(6, 5'b0), "reset_hold", 1'b1, 1'b1, 1'b1, 1'b1);
        tick(model(6, 5'b0), "idle_start", 1'b0, 1'b1, 1'b0, 1'b0);

        do_instr(5'b00011, 0, -1, -1, h);
        do_instr(5'b00011, 3, -1, -1, h);
        do_instr(5'b00001, 1, -1, -1, h);
        do_instr(5'b11011, 0, -1, -1, h);
        resume(2, 1'b0);
        do_instr(5'b11111, 0, -1, -1, h);
        do_instr(5'b00100, 2, 1, -1, h);
        if (h) resume(1, 1'b0);
        do_instr(5'b00100, 0, -1, 4, h);
        resume(1, 1'b0);
        do_instr(5'b00101, 0, -1, -1, h);
        do_instr(5'b11010, 0, 0, -1, h);
        if (h) resume(1, 1'b1);

        for (int n = 0; n < 80; n++) begin
            int r, stopc, clrc;
            r = $urandom_range(0, 9);
            case (r)
                0, 8: op = 5'b00011;
                1: op = 5'b00100;
                2: op = 5'b00101;
                3: op = 5'b00110;
                4, 9: op = 5'b00001;
                5: op = 5'b11010;
                6: op = 5'b11011;
                default: begin
                    op = 5'($urandom);
                    while (is_legal(op)) op = 5'($urandom);
                end
            endcase
            stopc = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 9) : -1;
            clrc  = ($urandom_range(0, 15) == 0) ? $urandom_range(0, 6) : -1;
            do_instr(op, $urandom_range(0, 3), stopc, clrc, h);
            if (h) resume($urandom_range(0, 2), 1'($urandom_range(0, 3) == 0));
        end

        clear = 0; start = 0; stop = 0;
        @(negedge clock); #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d want=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
